// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-interface definitions: fetch FSM encoding, NOP and default fetch parameters.
package instruction_fetch_pkg;

    localparam int unsigned IF_DATA_WIDTH = 32;
    localparam int unsigned IF_ADDR_WIDTH = 32;
    localparam int unsigned IF_INST_BYTES = 4;

    localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] IF_NOP      = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_if_id_reg.sv
// IF/ID pipeline register: hold beats bubble, bubble beats load.
module instruction_fetch_if_id_reg
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = IF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = IF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  hold,
    input  logic                  flush,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] inst,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic [ADDR_WIDTH-1:0] pc_next,
    output logic                  id_valid,
    output logic [DATA_WIDTH-1:0] id_inst,
    output logic [ADDR_WIDTH-1:0] id_pc,
    output logic [ADDR_WIDTH-1:0] id_pc_next
);

    // Bubbles clear valid and force a NOP; the PC fields keep their last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid   <= 1'b0;
            id_inst    <= '0;
            id_pc      <= '0;
            id_pc_next <= '0;
        end else if (hold) begin
            id_valid   <= id_valid;
        end else if (flush || !load) begin
            id_valid   <= 1'b0;
            id_inst    <= DATA_WIDTH'(IF_NOP);
        end else begin
            id_valid   <= 1'b1;
            id_inst    <= inst;
            id_pc      <= pc;
            id_pc_next <= pc_next;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: PC, single-outstanding imem handshake, redirect/discard handling and IF/ID register.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = IF_DATA_WIDTH,
    parameter int unsigned           ADDR_WIDTH = IF_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(IF_RESET_PC),
    parameter int unsigned           INST_BYTES = IF_INST_BYTES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fetch_stall,
    input  logic                  fetch_flush,
    input  logic                  decode_stall,
    input  logic                  fetch_branch,
    input  logic [ADDR_WIDTH-1:0] fetch_branch_target,
    output logic                  fetch_done,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  id_valid,
    output logic [DATA_WIDTH-1:0] id_inst,
    output logic [ADDR_WIDTH-1:0] id_pc,
    output logic [ADDR_WIDTH-1:0] id_pc_next
);

    localparam logic [ADDR_WIDTH-1:0] PC_INC = ADDR_WIDTH'(INST_BYTES);

    fetch_state_t          state;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  discard;
    logic [DATA_WIDTH-1:0] buf_inst;

    logic                  consume_c;
    logic [DATA_WIDTH-1:0] inst_c;
    logic [ADDR_WIDTH-1:0] pc_inc_c;

    // Handshake outputs and consume decode; rvalid bypasses straight to fetch_done.
    always_comb begin
        imem_req   = rst_n && enable && (state == S_IDLE);
        imem_addr  = (rst_n && fetch_branch) ? fetch_branch_target : pc;
        fetch_done = rst_n && enable &&
                     ((state == S_HOLD) ||
                      ((state == S_WAIT) && imem_rvalid && !discard));
        consume_c  = fetch_done && !fetch_stall && !fetch_flush && !fetch_branch;
        inst_c     = (state == S_HOLD) ? buf_inst : imem_rdata;
        pc_inc_c   = pc + PC_INC;
    end

    // Fetch FSM, PC and stale-response tracking; a redirect always wins over consume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            discard  <= 1'b0;
            buf_inst <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (imem_req && imem_gnt) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        discard <= 1'b0;
                        if (discard || fetch_branch || consume_c) begin
                            state <= S_IDLE;
                        end else begin
                            buf_inst <= imem_rdata;
                            state    <= S_HOLD;
                        end
                    end else if (fetch_branch) begin
                        discard <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (fetch_branch || consume_c) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            if (fetch_branch) begin
                pc <= fetch_branch_target;
            end else if (consume_c) begin
                pc <= pc_inc_c;
            end
        end
    end

    instruction_fetch_if_id_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_if_id_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .hold       (decode_stall),
        .flush      (fetch_flush),
        .load       (consume_c),
        .inst       (inst_c),
        .pc         (pc),
        .pc_next    (pc_inc_c),
        .id_valid   (id_valid),
        .id_inst    (id_inst),
        .id_pc      (id_pc),
        .id_pc_next (id_pc_next)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a small latency-programmable instruction memory.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        fetch_stall = 1'b0;
    logic        fetch_flush = 1'b0;
    logic        decode_stall = 1'b0;
    logic        fetch_branch = 1'b0;
    logic [31:0] fetch_branch_target = '0;
    logic        fetch_done;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc_next;

    int tests_run = 0;
    int tests_failed = 0;

    // memory model controls
    int          mem_lat = 1;
    logic        gnt_en = 1'b1;
    logic        pending = 1'b0;
    int          cnt = 0;
    logic [31:0] paddr = '0;

    instruction_fetch #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .RESET_PC   (32'h0),
        .INST_BYTES (4)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .enable              (enable),
        .fetch_stall         (fetch_stall),
        .fetch_flush         (fetch_flush),
        .decode_stall        (decode_stall),
        .fetch_branch        (fetch_branch),
        .fetch_branch_target (fetch_branch_target),
        .fetch_done          (fetch_done),
        .imem_req            (imem_req),
        .imem_addr           (imem_addr),
        .imem_gnt            (imem_gnt),
        .imem_rvalid         (imem_rvalid),
        .imem_rdata          (imem_rdata),
        .id_valid            (id_valid),
        .id_inst             (id_inst),
        .id_pc               (id_pc),
        .id_pc_next          (id_pc_next)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    // Memory: accepts req&gnt seen just before a rising edge, answers mem_lat cycles later.
    initial begin
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clk);
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
            if (pending) begin
                if (cnt <= 1) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_data(paddr);
                    pending     = 1'b0;
                end else begin
                    cnt = cnt - 1;
                end
            end
            #2 imem_gnt = gnt_en;
            #2;
            if (rst_n && imem_req && imem_gnt) begin
                pending = 1'b1;
                paddr   = imem_addr;
                cnt     = mem_lat;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; enable = 1'b0; fetch_stall = 1'b0; fetch_flush = 1'b0;
        decode_stall = 1'b0; fetch_branch = 1'b0; fetch_branch_target = '0;
        gnt_en = 1'b1; mem_lat = 1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1; enable = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; enable = 1'b1; fetch_branch = 1'b0;
        #1;
        tests_run++;
        if ({imem_req, fetch_done, id_valid} !== 3'b000 || imem_addr !== 32'h0 ||
            id_inst !== 32'h0 || id_pc !== 32'h0 || id_pc_next !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset: req/done/valid=%b addr=%h inst=%h pc=%h next=%h, expected 000 0 0 0 0",
                     {imem_req, fetch_done, id_valid}, imem_addr, id_inst, id_pc, id_pc_next);
        end
    endtask

    task automatic test_sequential();
        logic [2:0]  fl [7];
        logic [31:0] ad [7];
        logic [31:0] ip [7];
        fl = '{3'b100, 3'b010, 3'b101, 3'b010, 3'b101, 3'b010, 3'b101};
        ad = '{32'h0, 32'h0, 32'h4, 32'h4, 32'h8, 32'h8, 32'hC};
        ip = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h4, 32'h8};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            #1;
            tests_run++;
            if ({imem_req, fetch_done, id_valid} !== fl[i] || imem_addr !== ad[i]) begin
                tests_failed++;
                $display("FAIL seq cyc%0d: req/done/valid=%b addr=%h, expected %b %h",
                         i, {imem_req, fetch_done, id_valid}, imem_addr, fl[i], ad[i]);
            end
            if (fl[i][0]) begin
                tests_run++;
                if (id_pc !== ip[i] || id_pc_next !== ip[i] + 32'd4 || id_inst !== mem_data(ip[i])) begin
                    tests_failed++;
                    $display("FAIL seq_id cyc%0d: pc=%h next=%h inst=%h, expected %h %h %h",
                             i, id_pc, id_pc_next, id_inst, ip[i], ip[i] + 32'd4, mem_data(ip[i]));
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_slow_memory();
        logic [2:0]  fl [5];
        logic [31:0] ad [5];
        logic        sf [5];
        fl = '{3'b100, 3'b000, 3'b000, 3'b010, 3'b101};
        ad = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h4};
        sf = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        mem_lat = 3;
        for (int i = 0; i < 5; i++) begin
            fetch_stall = sf[i];
            fetch_flush = sf[i];
            #1;
            tests_run++;
            if ({imem_req, fetch_done, id_valid} !== fl[i] || imem_addr !== ad[i]) begin
                tests_failed++;
                $display("FAIL slow cyc%0d: req/done/valid=%b addr=%h, expected %b %h",
                         i, {imem_req, fetch_done, id_valid}, imem_addr, fl[i], ad[i]);
            end
            if (fl[i][0]) begin
                tests_run++;
                if (id_pc !== 32'h0 || id_inst !== mem_data(32'h0)) begin
                    tests_failed++;
                    $display("FAIL slow_id: pc=%h inst=%h, expected 0 %h", id_pc, id_inst, mem_data(32'h0));
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_redirect_wait();
        logic [2:0]  fl [9];
        logic [31:0] ad [9];
        logic        br [9];
        logic [31:0] tg [9];
        fl = '{3'b100, 3'b000, 3'b000, 3'b000, 3'b100, 3'b000, 3'b000, 3'b010, 3'b101};
        ad = '{32'h10, 32'h100, 32'h100, 32'h100, 32'h100, 32'h100, 32'h100, 32'h100, 32'h104};
        br = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tg = '{32'h10, 32'h100, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        do_reset();
        mem_lat = 3;
        for (int i = 0; i < 9; i++) begin
            fetch_branch = br[i];
            fetch_branch_target = tg[i];
            #1;
            tests_run++;
            if ({imem_req, fetch_done, id_valid} !== fl[i] || imem_addr !== ad[i]) begin
                tests_failed++;
                $display("FAIL redirect cyc%0d: req/done/valid=%b addr=%h, expected %b %h",
                         i, {imem_req, fetch_done, id_valid}, imem_addr, fl[i], ad[i]);
            end
            if (fl[i][0]) begin
                tests_run++;
                if (id_pc !== 32'h100 || id_pc_next !== 32'h104 || id_inst !== mem_data(32'h100)) begin
                    tests_failed++;
                    $display("FAIL redirect_id: pc=%h next=%h inst=%h, expected 100 104 %h",
                             id_pc, id_pc_next, id_inst, mem_data(32'h100));
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_decode_stall();
        logic [2:0]  fl [9];
        logic [31:0] ad [9];
        logic [31:0] ip [9];
        logic        st [9];
        fl = '{3'b100, 3'b010, 3'b101, 3'b011, 3'b011, 3'b011, 3'b101, 3'b010, 3'b101};
        ad = '{32'h20, 32'h20, 32'h24, 32'h24, 32'h24, 32'h24, 32'h28, 32'h28, 32'h2C};
        ip = '{32'h0, 32'h0, 32'h20, 32'h20, 32'h20, 32'h20, 32'h24, 32'h0, 32'h28};
        st = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            fetch_branch = (i == 0);
            fetch_branch_target = 32'h20;
            decode_stall = st[i];
            fetch_stall = st[i];
            #1;
            tests_run++;
            if ({imem_req, fetch_done, id_valid} !== fl[i] || imem_addr !== ad[i]) begin
                tests_failed++;
                $display("FAIL dstall cyc%0d: req/done/valid=%b addr=%h, expected %b %h",
                         i, {imem_req, fetch_done, id_valid}, imem_addr, fl[i], ad[i]);
            end
            if (fl[i][0]) begin
                tests_run++;
                if (id_pc !== ip[i] || id_pc_next !== ip[i] + 32'd4 || id_inst !== mem_data(ip[i])) begin
                    tests_failed++;
                    $display("FAIL dstall_id cyc%0d: pc=%h next=%h inst=%h, expected %h %h %h",
                             i, id_pc, id_pc_next, id_inst, ip[i], ip[i] + 32'd4, mem_data(ip[i]));
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_branch_issue();
        logic [2:0]  fl [5];
        logic [31:0] ad [5];
        logic [31:0] ip [5];
        fl = '{3'b100, 3'b010, 3'b101, 3'b010, 3'b101};
        ad = '{32'h40, 32'h40, 32'h44, 32'h44, 32'h48};
        ip = '{32'h0, 32'h0, 32'h40, 32'h0, 32'h44};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            fetch_branch = (i == 0);
            fetch_branch_target = 32'h40;
            #1;
            tests_run++;
            if ({imem_req, fetch_done, id_valid} !== fl[i] || imem_addr !== ad[i]) begin
                tests_failed++;
                $display("FAIL brissue cyc%0d: req/done/valid=%b addr=%h, expected %b %h",
                         i, {imem_req, fetch_done, id_valid}, imem_addr, fl[i], ad[i]);
            end
            if (fl[i][0]) begin
                tests_run++;
                if (id_pc !== ip[i] || id_pc_next !== ip[i] + 32'd4 || id_inst !== mem_data(ip[i])) begin
                    tests_failed++;
                    $display("FAIL brissue_id cyc%0d: pc=%h next=%h inst=%h, expected %h %h %h",
                             i, id_pc, id_pc_next, id_inst, ip[i], ip[i] + 32'd4, mem_data(ip[i]));
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_pc_wrap();
        do_reset();
        fetch_branch = 1'b1;
        fetch_branch_target = 32'hFFFF_FFFC;
        @(negedge clk);
        fetch_branch = 1'b0;
        @(negedge clk);
        #1;
        tests_run++;
        if (id_valid !== 1'b1 || id_pc !== 32'hFFFF_FFFC || id_pc_next !== 32'h0 || imem_addr !== 32'h0) begin
            tests_failed++;
            $display("FAIL wrap: valid=%b pc=%h next=%h addr=%h, expected 1 fffffffc 0 0",
                     id_valid, id_pc, id_pc_next, imem_addr);
        end
    endtask

    task automatic test_enable_low();
        logic [2:0]  fl [6];
        logic [31:0] ad [6];
        logic        en [6];
        fl = '{3'b100, 3'b000, 3'b000, 3'b010, 3'b001, 3'b100};
        ad = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h4};
        en = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            enable = en[i];
            #1;
            tests_run++;
            if ({imem_req, fetch_done, id_valid} !== fl[i] || imem_addr !== ad[i]) begin
                tests_failed++;
                $display("FAIL enable cyc%0d: req/done/valid=%b addr=%h, expected %b %h",
                         i, {imem_req, fetch_done, id_valid}, imem_addr, fl[i], ad[i]);
            end
            if (fl[i][0]) begin
                tests_run++;
                if (id_pc !== 32'h0 || id_inst !== mem_data(32'h0)) begin
                    tests_failed++;
                    $display("FAIL enable_id: pc=%h inst=%h, expected 0 %h", id_pc, id_inst, mem_data(32'h0));
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_request();
        do_reset();
        fetch_branch = 1'b1;
        fetch_branch_target = 32'h80;
        @(negedge clk);
        fetch_branch = 1'b0;
        @(negedge clk);
        mem_lat = 3;
        #1;
        tests_run++;
        if (id_valid !== 1'b1 || id_pc !== 32'h80 || imem_addr !== 32'h84 || imem_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstmid_pre: valid=%b pc=%h addr=%h req=%b, expected 1 80 84 1",
                     id_valid, id_pc, imem_addr, imem_req);
        end
        @(negedge clk);
        gnt_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({imem_req, fetch_done, id_valid} !== 3'b000 || imem_addr !== 32'h0 ||
            id_pc !== 32'h0 || id_pc_next !== 32'h0 || id_inst !== 32'h0) begin
            tests_failed++;
            $display("FAIL rstmid_async: req/done/valid=%b addr=%h pc=%h next=%h inst=%h, expected 000 0 0 0 0",
                     {imem_req, fetch_done, id_valid}, imem_addr, id_pc, id_pc_next, id_inst);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                gnt_en = 1'b1;
                mem_lat = 1;
            end
            #1;
            tests_run++;
            if (i < 3 && ({imem_req, fetch_done, id_valid} !== 3'b100 || imem_addr !== 32'h0)) begin
                tests_failed++;
                $display("FAIL rstmid_idle cyc%0d: req/done/valid=%b addr=%h rvalid=%b, expected 100 0",
                         i, {imem_req, fetch_done, id_valid}, imem_addr, imem_rvalid);
            end
            if (i == 3 && {imem_req, fetch_done, id_valid} !== 3'b010) begin
                tests_failed++;
                $display("FAIL rstmid_resp: req/done/valid=%b, expected 010", {imem_req, fetch_done, id_valid});
            end
            if (i == 4 && (id_valid !== 1'b1 || id_pc !== 32'h0 || id_pc_next !== 32'h4 ||
                           id_inst !== mem_data(32'h0))) begin
                tests_failed++;
                $display("FAIL rstmid_id: valid=%b pc=%h next=%h inst=%h, expected 1 0 4 %h",
                         id_valid, id_pc, id_pc_next, id_inst, mem_data(32'h0));
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_slow_memory();
        test_redirect_wait();
        test_decode_stall();
        test_branch_issue();
        test_pc_wrap();
        test_enable_low();
        test_reset_mid_request();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- IF stage of the 5-stage pipeline; the consumer end of the hazard controller's fetch interface.
- Owns the PC and the single-outstanding-request instruction-memory handshake.
- Owns the IF/ID pipeline register.
- Reports `fetch_done` back to the controller, and obeys its stall, flush and branch-redirect outputs.

Parameters:
- DATA_WIDTH, 32, instruction width
- ADDR_WIDTH, 32, PC / memory address width
- RESET_PC, 0, PC value after reset
- INST_BYTES, 4, PC increment per sequential instruction

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- enable  in  1  executing (flash loader done, not halted); low = issue nothing, ID gets bubbles
- fetch_stall  in  1  controller: do not advance PC / consume instruction
- fetch_flush  in  1  controller: load bubble into IF/ID (unless decode_stall)
- decode_stall  in  1  controller: IF/ID register must hold
- fetch_branch  in  1  redirect request this cycle
- fetch_branch_target  in  ADDR_WIDTH  redirect PC
- fetch_done  out  1  a valid, non-stale instruction is available this cycle
- imem_req  out  1  memory read request
- imem_addr  out  ADDR_WIDTH  request address
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  read data valid (≥1 cycle after gnt)
- imem_rdata  in  DATA_WIDTH  read data
- id_valid  out  1  IF/ID holds a real instruction
- id_inst  out  DATA_WIDTH  IF/ID instruction
- id_pc  out  ADDR_WIDTH  PC of id_inst
- id_pc_next  out  ADDR_WIDTH  id_pc + INST_BYTES

Behaviour:
- **Reset.** Clock clk; reset rst_n, asynchronous, active-low.
  - Reset values: pc = RESET_PC, state = S_IDLE, discard = 0, buffer empty.
  - All outputs 0, except imem_addr = RESET_PC.
- **FSM.**
  - S_IDLE: no request outstanding.
    - imem_req = enable.
    - imem_gnt → S_WAIT.
  - S_WAIT: one request outstanding, imem_req = 0.
    - imem_rvalid with discard = 1: drop data, clear discard → S_IDLE.
    - imem_rvalid with discard = 0 and instruction not consumed this cycle: latch into buffer → S_HOLD.
    - imem_rvalid with discard = 0 and instruction consumed this cycle (bypass): → S_IDLE.
  - S_HOLD: buffer valid, imem_req = 0.
    - Consumed → S_IDLE.
- **Request address.** imem_addr = fetch_branch ? fetch_branch_target : pc. A redirect on the same cycle as issue fetches the target directly.
- **fetch_done.** fetch_done = (S_HOLD) | (S_WAIT & imem_rvalid & !discard). Combinational bypass; zero-cycle latency from rvalid to done.
- **Consume.** consume = fetch_done & !fetch_stall & !fetch_flush & !fetch_branch & enable. On consume:
  - id_valid <= 1; id_inst <= instruction; id_pc <= pc; id_pc_next <= pc + INST_BYTES.
  - pc <= pc + INST_BYTES; buffer freed.
- **IF/ID priority.**
  1. decode_stall → hold all id_* outputs.
  2. else fetch_flush | !consume → id_valid <= 0; id_inst <= 0 (NOP).
  3. else load as in Consume.
- **Redirect (fetch_branch = 1).** Highest priority over consume.
  - pc <= fetch_branch_target.
  - S_HOLD: buffer dropped → S_IDLE.
  - S_WAIT without rvalid this cycle: discard <= 1.
  - S_WAIT with rvalid this cycle: data dropped → S_IDLE.
  - S_IDLE with gnt: the request is to the target, so next pc = target; pc + INST_BYTES is applied on consume.
- **enable low mid-request.** The outstanding response is still absorbed (no request abandoned on the bus); no new request is issued; fetch_done is forced to 0.
- **Arithmetic.** PC increment wraps modulo 2^ADDR_WIDTH, no overflow flag. Addresses are not alignment-checked.
- **Simultaneous events.**
  - branch + rvalid on the same cycle: data is stale, dropped.
  - branch twice while in S_WAIT: discard stays 1; only the last target is kept.

Decomposition:
- Shared package (with the hazard controller):
  - FSM state encoding for S_IDLE, S_WAIT, S_HOLD.
  - NOP encoding, 32'h0.
  - INST_BYTES.
  - Default RESET_PC.
- Natural sub-module: `if_id_reg`, the IF/ID register with hold/bubble/load priority. The fetch FSM stays in the top.

Test Plan:
1. **Sequential fetch.** RESET_PC = 0, gnt always 1, rvalid 1 cycle after gnt, all stalls 0 → id_pc 0, 4, 8 on consecutive fetches; id_pc_next 4, 8, 12; id_valid 1 only on cycles after fetch_done.
2. **Slow memory.** rvalid 3 cycles after gnt → fetch_done 0 for 2 cycles; with fetch_stall = fetch_flush = 1 (controller mirror), id_valid 0 during those cycles; single request outstanding, imem_req 0 in S_WAIT.
3. **Redirect while waiting.** Request to 0x10 outstanding, fetch_branch = 1 with target 0x100 → returning 0x10 data dropped (fetch_done 0); next imem_addr = 0x100; first valid id_pc = 0x100.
4. **decode_stall hold.** id_pc = 0x20 loaded, decode_stall = 1 for 3 cycles with rvalid arriving → id_* unchanged; instruction buffered in S_HOLD; after release, id_pc = 0x24 next cycle, no instruction lost or duplicated.
5. **Branch on issue cycle.** S_IDLE, fetch_branch = 1 with target 0x40, gnt = 1 → imem_addr = 0x40 the same cycle; response consumed gives id_pc = 0x40, then 0x44.
6. **Reset mid-request.** Assert rst_n low while in S_WAIT → outputs 0 immediately; after release, first imem_addr = RESET_PC; late rvalid from the old request is ignored.
